// File: rtl/req_ack_arb_if.sv
// Requester/downstream bundle for req_ack_arb. The master side drives requests
// and downstream ready; the slave side is the arbiter.
interface req_ack_arb_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        ack;
    logic [NUM_CH-1:0]        ack_pulse;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic [NUM_CH-1:0]        timeout_err;
    logic                     err_clr;

    modport master (
        output req, req_data, out_ready, err_clr,
        input  ack, ack_pulse, out_valid, out_data, out_ch, timeout_err
    );
    modport slave (
        input  req, req_data, out_ready, err_clr,
        output ack, ack_pulse, out_valid, out_data, out_ch, timeout_err
    );
endinterface

// File: rtl/req_ack_arb.sv
// Round-robin arbiter of NUM_CH req/ack requesters onto one valid/ready port,
// with four-phase or streaming ack and optional per-channel stall timeout.
module req_ack_arb_ch #(
    parameter int STREAM_MODE = 0,
    parameter int TIMEOUT     = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic req,
    input  logic won,
    input  logic err_clr,
    output logic elig,
    output logic ack_lvl,
    output logic timeout_err
);
    logic ack_r;
    logic unused_in;

    assign unused_in = &{1'b0, won, err_clr};

    if (STREAM_MODE == 0) begin : g_lvl
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)     ack_r <= 1'b0;
            else if (won)  ack_r <= 1'b1;
            else if (!req) ack_r <= 1'b0;
        end
    end else begin : g_strm
        assign ack_r = 1'b0;
    end

    assign elig    = req & ~ack_r;
    assign ack_lvl = ack_r;

    if (TIMEOUT > 0) begin : g_to
        localparam int CW = $clog2(TIMEOUT + 1);
        localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);
        logic [CW-1:0] cnt;
        logic          pend, hit;

        assign pend = elig & ~won;
        assign hit  = pend & (cnt == CMAX - 1'b1);

        // A saturated counter rearms on err_clr so a still-stalled channel re-flags.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt         <= '0;
                timeout_err <= 1'b0;
            end else begin
                if (!pend)             cnt <= '0;
                else if (cnt != CMAX)  cnt <= cnt + 1'b1;
                else if (err_clr)      cnt <= '0;
                if (hit)               timeout_err <= 1'b1;
                else if (err_clr)      timeout_err <= 1'b0;
            end
        end
    end else begin : g_no_to
        assign timeout_err = 1'b0;
    end
endmodule

module req_ack_arb #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int STREAM_MODE = 0,
    parameter int TIMEOUT     = 0,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input logic          clk,
    input logic          rstn,
    req_ack_arb_if.slave bus
);
    logic [NUM_CH-1:0]             elig, won, ack_lvl, to_err;
    logic [NUM_CH-1:0][DATA_W-1:0] data_a;
    logic [CH_W-1:0]               rr_ptr, sel, idx;
    logic                          any_elig, xfer;

    assign data_a = bus.req_data;

    // First eligible channel at or after rr_ptr, wrapping.
    always_comb begin
        sel      = '0;
        idx      = '0;
        any_elig = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                sel      = idx;
            end
        end
    end

    assign xfer = any_elig & bus.out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     rr_ptr <= '0;
        else if (xfer) rr_ptr <= (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign won[i] = xfer & (sel == CH_W'(i));
        req_ack_arb_ch #(
            .STREAM_MODE (STREAM_MODE),
            .TIMEOUT     (TIMEOUT)
        ) u_ch (
            .clk         (clk),
            .rstn        (rstn),
            .req         (bus.req[i]),
            .won         (won[i]),
            .err_clr     (bus.err_clr),
            .elig        (elig[i]),
            .ack_lvl     (ack_lvl[i]),
            .timeout_err (to_err[i])
        );
    end

    assign bus.out_valid   = any_elig;
    assign bus.out_ch      = sel;
    assign bus.out_data    = any_elig ? data_a[sel] : '0;
    assign bus.ack_pulse   = won;
    assign bus.ack         = (STREAM_MODE != 0) ? won : ack_lvl;
    assign bus.timeout_err = to_err;
endmodule
